dbus_axi_bridge: RTL and testbench

- Converts the core's simple DBus AXI-region port into AXI4-Lite master transactions.
- Consumes the core outputs axi_rd_en, axi_wr_en, axi_addr, wr_data and wr_strobe.
- Returns axi_rd_data, axi_access_fault and axi_busy to the core.
- Sits between the core and the SoC interconnect. One outstanding transaction at a time; the core stalls while axi_busy=1.

---
 rtl/lexington_pkg.sv | 23 ++
 rtl/dbus_axi_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_dbus_axi_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lexington_pkg.sv
// Shared types and defaults for the lexington core's bus bridges.
package lexington_pkg;

    localparam int DEFAULT_AXI_ADDR_WIDTH     = 32;
    localparam int DEFAULT_AXI_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } dbus_axi_state_t;

endpackage

// File: rtl/dbus_axi_bridge.sv
// DBus AXI-region port to AXI4-Lite master, one transaction in flight.
// Optional handshake timeout enabled by defining LEXINGTON_AXI_TIMEOUT_EN.
module dbus_axi_bridge
    import lexington_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      axi_rd_en,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               axi_rd_data,
    output logic                      axi_access_fault,
    output logic                      axi_busy,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    dbus_axi_state_t           state;
    logic                      aw_done;
    logic                      w_done;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      phase_done;
    logic                      tmo;
    logic                      unused_addr_lo;

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

    // Accesses are word-aligned; the byte offset is carried by the strobes.
    assign unused_addr_lo = ^axi_addr[1:0];

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    always_comb begin
        axi_busy = 1'b0;
        case (state)
            IDLE:                              axi_busy = axi_rd_en || axi_wr_en;
            WR_ADDR, WR_RESP, RD_ADDR, RD_DATA: axi_busy = 1'b1;
            default:                           axi_busy = 1'b0;
        endcase
    end

    // The wait state the FSM is in completes this cycle.
    always_comb begin
        phase_done = 1'b0;
        case (state)
            WR_ADDR: phase_done = (aw_done || aw_hs) && (w_done || w_hs);
            WR_RESP: phase_done = m_bvalid;
            RD_ADDR: phase_done = m_arready;
            RD_DATA: phase_done = m_rvalid;
            default: phase_done = 1'b0;
        endcase
    end

`ifdef LEXINGTON_AXI_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state == IDLE || phase_done) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES);
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    // Final cycle of the budget with the handshake still outstanding.
    assign tmo = (state == WR_ADDR || state == WR_RESP || state == RD_ADDR || state == RD_DATA)
                 && (tmr == TMR_W'(1)) && !phase_done;
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            m_awvalid        <= 1'b0;
            m_wvalid         <= 1'b0;
            m_bready         <= 1'b0;
            m_arvalid        <= 1'b0;
            m_rready         <= 1'b0;
            axi_rd_data      <= '0;
            axi_access_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (axi_rd_en && axi_wr_en) begin
                        axi_access_fault <= 1'b1;
                        state            <= DONE;
                    end else if (axi_wr_en) begin
                        addr_q    <= {axi_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
                        wdata_q   <= wr_data;
                        wstrb_q   <= wr_strobe;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= WR_ADDR;
                    end else if (axi_rd_en) begin
                        addr_q    <= {axi_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
                        m_arvalid <= 1'b1;
                        state     <= RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (tmo) begin
                        m_awvalid        <= 1'b0;
                        m_wvalid         <= 1'b0;
                        axi_access_fault <= 1'b1;
                        state            <= DONE;
                    end else begin
                        if (aw_hs) begin
                            m_awvalid <= 1'b0;
                            aw_done   <= 1'b1;
                        end
                        if (w_hs) begin
                            m_wvalid <= 1'b0;
                            w_done   <= 1'b1;
                        end
                        if (phase_done) begin
                            m_bready <= 1'b1;
                            state    <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (phase_done) begin
                        m_bready         <= 1'b0;
                        axi_access_fault <= (axi_resp_t'(m_bresp) != OKAY);
                        state            <= DONE;
                    end else if (tmo) begin
                        m_bready         <= 1'b0;
                        axi_access_fault <= 1'b1;
                        state            <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (phase_done) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= RD_DATA;
                    end else if (tmo) begin
                        m_arvalid        <= 1'b0;
                        axi_access_fault <= 1'b1;
                        state            <= DONE;
                    end
                end
                RD_DATA: begin
                    if (phase_done) begin
                        m_rready         <= 1'b0;
                        axi_rd_data      <= m_rdata;
                        // AXI4-Lite has no exclusive access, so EXOKAY is an error too.
                        axi_access_fault <= (axi_resp_t'(m_rresp) != OKAY);
                        state            <= DONE;
                    end else if (tmo) begin
                        m_rready         <= 1'b0;
                        axi_access_fault <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    axi_access_fault <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_axi_bridge.sv
// Randomised scoreboard bench for dbus_axi_bridge with a memory-backed AXI4-Lite slave.
module tb_dbus_axi_bridge;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          axi_rd_en, axi_wr_en;
    logic [AW-1:0] axi_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strobe;
    logic [31:0]   axi_rd_data;
    logic          axi_access_fault, axi_busy;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0]   m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    always #5 clk = ~clk;

    dbus_axi_bridge #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe),
        .axi_rd_data(axi_rd_data), .axi_access_fault(axi_access_fault), .axi_busy(axi_busy),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a word memory with byte strobes, plus the last read value.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] last_rd = 32'h0;

    function automatic logic [31:0] dflt(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] slv_rd(logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        int          n_ar;
        int          n_aw;
        int          n_w;
        int          busy;
        bit          novld;
    } exp_t;

    exp_t exp_q[$];

    // Slave configuration for the transaction in flight.
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] exp_awaddr = 0, exp_wdata = 0, exp_araddr = 0;
    logic [3:0]  exp_wstrb = 0;

    int n_ar = 0, n_aw = 0, n_w = 0, vld_cycles = 0;

    // Slave: drives ready/valid just after the rising edge, observes handshakes at the falling edge.
    initial begin
        bit          aw_seen, w_seen, b_pend, r_pend;
        logic [31:0] cap_awaddr, cap_wdata, r_addr;
        logic [3:0]  cap_wstrb;
        logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awaddr, p_araddr;
        aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
        cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0; r_addr = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awaddr = 0; p_araddr = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            end else begin
                if (m_awvalid) begin
                    if (aw_wait == 0) m_awready = 1;
                    else begin m_awready = 0; aw_wait--; end
                end else m_awready = 0;
                if (m_wvalid) begin
                    if (w_wait == 0) m_wready = 1;
                    else begin m_wready = 0; w_wait--; end
                end else m_wready = 0;
                if (m_arvalid) begin
                    if (ar_wait == 0) m_arready = 1;
                    else begin m_arready = 0; ar_wait--; end
                end else m_arready = 0;
                if (b_pend) begin
                    if (b_wait == 0) begin m_bvalid = 1; m_bresp = cfg_bresp; end
                    else b_wait--;
                end else begin
                    m_bvalid = 0; m_bresp = 2'($urandom);
                end
                if (r_pend) begin
                    if (r_wait == 0) begin m_rvalid = 1; m_rdata = slv_rd(r_addr); m_rresp = cfg_rresp; end
                    else r_wait--;
                end else begin
                    m_rvalid = 0; m_rdata = $urandom; m_rresp = 2'($urandom);
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
                p_awv = 0; p_wv = 0; p_arv = 0;
            end else begin
                if (m_awvalid || m_wvalid || m_arvalid) vld_cycles++;
                if (axi_busy && p_awv && !p_awr) begin
                    chk("awvalid_held", m_awvalid, 1);
                    chk("awaddr_stable", m_awaddr, p_awaddr);
                end
                if (axi_busy && p_wv && !p_wr) chk("wvalid_held", m_wvalid, 1);
                if (axi_busy && p_arv && !p_arr) begin
                    chk("arvalid_held", m_arvalid, 1);
                    chk("araddr_stable", m_araddr, p_araddr);
                end
                if (m_bvalid && m_bready) begin
                    b_pend = 0;
                    if (cfg_bresp == 2'b00) slv_mem[cap_awaddr] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);
                end
                if (m_rvalid && m_rready) r_pend = 0;
                if (m_awvalid && m_awready) begin
                    n_aw++;
                    chk("awaddr", m_awaddr, exp_awaddr);
                    chk("awprot", 32'(m_awprot), 0);
                    cap_awaddr = m_awaddr;
                    aw_seen = 1;
                end
                if (m_wvalid && m_wready) begin
                    n_w++;
                    chk("wdata", m_wdata, exp_wdata);
                    chk("wstrb", 32'(m_wstrb), 32'(exp_wstrb));
                    cap_wdata = m_wdata;
                    cap_wstrb = m_wstrb;
                    w_seen = 1;
                end
                if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
                if (m_arvalid && m_arready) begin
                    n_ar++;
                    chk("araddr", m_araddr, exp_araddr);
                    chk("arprot", 32'(m_arprot), 0);
                    r_addr = m_araddr;
                    r_pend = 1;
                end
                p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
                p_wv = m_wvalid; p_wr = m_wready;
                p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
            end
        end
    end

    // Monitor: the cycle where busy falls is the completion cycle; pop and compare there.
    initial begin
        bit   prev_busy, prev_done;
        int   blen;
        exp_t e;
        prev_busy = 0; prev_done = 0; blen = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_busy = 0; prev_done = 0; blen = 0;
                n_ar = 0; n_aw = 0; n_w = 0; vld_cycles = 0;
            end else begin
                if (prev_done) chk("fault_cleared", 32'(axi_access_fault), 0);
                prev_done = 0;
                if (axi_busy) blen++;
                else if (prev_busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: actual=completion expected=none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", axi_rd_data, e.rd);
                        chk("fault", 32'(axi_access_fault), 32'(e.flt));
                        chk("ar_handshakes", n_ar, e.n_ar);
                        chk("aw_handshakes", n_aw, e.n_aw);
                        chk("w_handshakes", n_w, e.n_w);
                        if (e.busy != 0) chk("busy_cycles", blen, e.busy);
                        if (e.novld) chk("no_valid_cycles", vld_cycles, 0);
                    end
                    n_ar = 0; n_aw = 0; n_w = 0; vld_cycles = 0;
                    blen = 0;
                    prev_done = 1;
                end
                prev_busy = axi_busy;
            end
        end
    end

    task automatic finish_bench();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (axi_busy && n < 300);
        if (axi_busy) begin
            checks++;
            errors++;
            $display("FAIL txn_complete: actual=still_busy expected=done after %0d cycles", n);
            finish_bench();
        end
    endtask

    // kind: 0 read, 1 write, 2 read+write together, 3 read whose address phase never completes.
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp,
                         input int a_w, input int d_w, input int r_w, input int exp_busy);
        exp_t        e;
        logic [31:0] word;
        word = {addr[31:2], 2'b00};
        e.busy = exp_busy; e.novld = 0; e.n_ar = 0; e.n_aw = 0; e.n_w = 0;
        e.rd = last_rd; e.flt = (resp != 2'b00);
        axi_addr = addr; wr_data = data; wr_strobe = strb;
        axi_rd_en = 0; axi_wr_en = 0;
        case (kind)
            0: begin
                axi_rd_en = 1;
                exp_araddr = word; ar_wait = a_w; r_wait = r_w; cfg_rresp = resp;
                last_rd = ref_rd(word);
                e.rd = last_rd; e.n_ar = 1;
            end
            1: begin
                axi_wr_en = 1;
                exp_awaddr = word; exp_wdata = data; exp_wstrb = strb;
                aw_wait = a_w; w_wait = d_w; b_wait = r_w; cfg_bresp = resp;
                if (resp == 2'b00) ref_mem[word] = merge(ref_rd(word), data, strb);
                e.n_aw = 1; e.n_w = 1;
            end
            2: begin
                axi_rd_en = 1; axi_wr_en = 1;
                e.flt = 1; e.novld = 1;
            end
            default: begin
                axi_rd_en = 1;
                exp_araddr = word; ar_wait = 100000; r_wait = 0; cfg_rresp = 2'b00;
                e.flt = 1;
            end
        endcase
        exp_q.push_back(e);
        wait_done();
    endtask

    task automatic idle(input int n);
        axi_rd_en = 0;
        axi_wr_en = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          kind, r, n;
        logic [31:0] a;
        logic [1:0]  resp;
        axi_rd_en = 0; axi_wr_en = 0; axi_addr = 0; wr_data = 0; wr_strobe = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", axi_rd_data, 0);
        chk("rst_fault", 32'(axi_access_fault), 0);
        chk("rst_busy", 32'(axi_busy), 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
        chk("rst_readys", {m_bready, m_rready}, 0);
        chk("rst_addr", m_araddr, 0);
        chk("rst_wdata", m_wdata, 0);
        rst_n = 1;
        idle(2);

        ref_mem[32'h104] = 32'h1234_5678;
        slv_mem[32'h104] = 32'h1234_5678;
        issue(0, 32'h0000_0104, 32'h0, 4'hF, 2'b00, 0, 0, 0, 3);
        idle(2);
        issue(1, 32'h0000_0203, 32'hCAFE_F00D, 4'b0011, 2'b00, 0, 3, 0, 0);
        idle(1);
        issue(0, 32'h0000_0200, 32'h0, 4'h0, 2'b00, 0, 0, 0, 3);
        idle(1);
        issue(0, 32'h0000_0300, 32'h0, 4'h0, 2'b10, 0, 0, 0, 3);
        idle(1);
        issue(1, 32'h0000_0304, 32'h0BAD_BEEF, 4'hF, 2'b11, 0, 0, 0, 3);
        idle(1);
        issue(0, 32'h0000_0304, 32'h0, 4'h0, 2'b01, 1, 0, 2, 0);
        idle(1);
        issue(2, 32'h0000_0308, 32'h5555_AAAA, 4'hF, 2'b00, 0, 0, 0, 1);
        idle(2);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            kind = (r < 45) ? 0 : (r < 90) ? 1 : 2;
            a = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            resp = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            issue(kind, a, $urandom, 4'($urandom), resp,
                  $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 0);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(2);

`ifdef LEXINGTON_AXI_TIMEOUT_EN
        issue(3, 32'h0000_0040, 32'h0, 4'h0, 2'b00, 0, 0, 0, 9);
        idle(2);
        issue(0, 32'h0000_0104, 32'h0, 4'h0, 2'b00, 0, 0, 0, 3);
        idle(2);
`endif

        exp_araddr = 32'h80; ar_wait = 0; r_wait = 8; cfg_rresp = 2'b00;
        axi_addr = 32'h80; axi_rd_en = 1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_rready && n < 20);
        chk("reached_rd_data", 32'(m_rready), 1);
        #2;
        rst_n = 0;
        axi_rd_en = 0;
        #1;
        chk("abort_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
        chk("abort_readys", {m_bready, m_rready}, 0);
        chk("abort_rd_data", axi_rd_data, 0);
        chk("abort_fault", 32'(axi_access_fault), 0);
        chk("abort_busy", 32'(axi_busy), 0);
        last_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);
        issue(0, 32'h0000_0104, 32'h0, 4'h0, 2'b00, 0, 0, 0, 3);
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        finish_bench();
    end

endmodule
